// File: rtl/motion_sequencer.sv
// Command sequencer for a multi-axis stepper controller: buffers host commands,
// then strobes and supervises the stepper controller one command at a time.
module motion_sequencer #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [2:0]  cmd_home_axes,
    input  logic [31:0] cmd_step_1,
    input  logic [31:0] cmd_step_2,
    input  logic [31:0] cmd_step_3,
    input  logic [31:0] cmd_step_4,
    input  logic [31:0] cmd_speed_1,
    input  logic [31:0] cmd_speed_2,
    input  logic [31:0] cmd_speed_3,
    input  logic [31:0] cmd_speed_4,
    input  logic        motors_on,
    input  logic        abort,
    input  logic        fault_clr,
    input  logic        steppers_driving,
    output logic [31:0] stepper_step_in_1,
    output logic [31:0] stepper_step_in_2,
    output logic [31:0] stepper_step_in_3,
    output logic [31:0] stepper_step_in_4,
    output logic [31:0] stepper_speed_1,
    output logic [31:0] stepper_speed_2,
    output logic [31:0] stepper_speed_3,
    output logic [31:0] stepper_speed_4,
    output logic        homex,
    output logic        homey,
    output logic        homez,
    output logic        start_driving,
    output logic        start_homing,
    output logic        stepper_enable,
    output logic        cmd_done,
    output logic        busy,
    output logic        fault,
    output logic [4:0]  queue_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

    logic [1:0]   type_mem  [DEPTH];
    logic [2:0]   axes_mem  [DEPTH];
    logic [127:0] step_mem  [DEPTH];
    logic [127:0] speed_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q;
    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fault_q, fault_d, fault_set;
    logic          en_q, home_mode_q;
    logic [127:0]  step_q, speed_q;
    logic [2:0]    home_q;

    logic [1:0]    head_type;
    logic [2:0]    head_axes;
    logic [127:0]  head_step;
    logic          head_noop, push, pop, strobe_on;

    assign head_type = type_mem[rd_ptr_q];
    assign head_axes = axes_mem[rd_ptr_q];
    assign head_step = step_mem[rd_ptr_q];
    assign head_noop = ((head_type == 2'd0) && (head_step == '0)) ||
                       ((head_type == 2'd1) && (head_axes == 3'b000));

    assign cmd_ready = reset_n & ~abort & (count_q < 5'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state_q == S_LOAD);

    // Storage only; occupancy and pointers carry the reset.
    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr_q]  <= cmd_type;
            axes_mem[wr_ptr_q]  <= cmd_home_axes;
            step_mem[wr_ptr_q]  <= {cmd_step_4, cmd_step_3, cmd_step_2, cmd_step_1};
            speed_mem[wr_ptr_q] <= {cmd_speed_4, cmd_speed_3, cmd_speed_2, cmd_speed_1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + 5'(push) - 5'(pop);
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        fault_set = 1'b0;
        case (state_q)
            S_IDLE: if (count_q != '0 && !abort) state_d = S_LOAD;
            S_LOAD: begin
                if (head_type[1]) begin
                    state_d   = S_DONE;
                    fault_set = 1'b1;
                end else if (head_noop) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (steppers_driving) begin
                    state_d = S_RUN;
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    fault_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RUN:  if (abort || !steppers_driving) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A new fault event outranks a simultaneous clear.
        fault_d = fault_set | (fault_q & ~fault_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            fault_q     <= 1'b0;
            en_q        <= 1'b0;
            home_mode_q <= 1'b0;
            step_q      <= '0;
            speed_q     <= '0;
            home_q      <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            en_q    <= motors_on | (state_d != S_IDLE);
            if (state_q == S_LOAD) begin
                home_mode_q <= (head_type == 2'd1);
                step_q      <= head_step;
                speed_q     <= speed_mem[rd_ptr_q];
                home_q      <= (head_type == 2'd1) ? head_axes : 3'b000;
            end
        end
    end

    assign strobe_on     = (state_q == S_ARM) || (state_q == S_RUN);
    assign start_driving = strobe_on & ~home_mode_q;
    assign start_homing  = strobe_on & home_mode_q;
    assign cmd_done      = (state_q == S_DONE);
    assign busy          = (count_q != '0) || (state_q != S_IDLE);
    assign fault         = fault_q;
    assign queue_count   = count_q;
    assign stepper_enable = en_q;

    assign {stepper_step_in_4, stepper_step_in_3, stepper_step_in_2, stepper_step_in_1} = step_q;
    assign {stepper_speed_4, stepper_speed_3, stepper_speed_2, stepper_speed_1}         = speed_q;
    assign {homez, homey, homex} = home_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_motion_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [2:0]  cmd_home_axes;
    logic [31:0] cmd_step_1, cmd_step_2, cmd_step_3, cmd_step_4;
    logic [31:0] cmd_speed_1, cmd_speed_2, cmd_speed_3, cmd_speed_4;
    logic        motors_on, abort, fault_clr, steppers_driving;
    logic [31:0] stepper_step_in_1, stepper_step_in_2, stepper_step_in_3, stepper_step_in_4;
    logic [31:0] stepper_speed_1, stepper_speed_2, stepper_speed_3, stepper_speed_4;
    logic        homex, homey, homez;
    logic        start_driving, start_homing, stepper_enable;
    logic        cmd_done, busy, fault;
    logic [4:0]  queue_count;

    int tests = 0;
    int fails = 0;

    motion_sequencer #(.DEPTH(4), .ACK_TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_home_axes(cmd_home_axes),
        .cmd_step_1(cmd_step_1), .cmd_step_2(cmd_step_2),
        .cmd_step_3(cmd_step_3), .cmd_step_4(cmd_step_4),
        .cmd_speed_1(cmd_speed_1), .cmd_speed_2(cmd_speed_2),
        .cmd_speed_3(cmd_speed_3), .cmd_speed_4(cmd_speed_4),
        .motors_on(motors_on), .abort(abort), .fault_clr(fault_clr),
        .steppers_driving(steppers_driving),
        .stepper_step_in_1(stepper_step_in_1), .stepper_step_in_2(stepper_step_in_2),
        .stepper_step_in_3(stepper_step_in_3), .stepper_step_in_4(stepper_step_in_4),
        .stepper_speed_1(stepper_speed_1), .stepper_speed_2(stepper_speed_2),
        .stepper_speed_3(stepper_speed_3), .stepper_speed_4(stepper_speed_4),
        .homex(homex), .homey(homey), .homez(homez),
        .start_driving(start_driving), .start_homing(start_homing),
        .stepper_enable(stepper_enable),
        .cmd_done(cmd_done), .busy(busy), .fault(fault), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [1:0] t, input logic [2:0] ax,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] s3, input logic [31:0] s4);
        cmd_type      = t;
        cmd_home_axes = ax;
        cmd_step_1 = s1; cmd_step_2 = s2; cmd_step_3 = s3; cmd_step_4 = s4;
        cmd_speed_1 = s1 + 32'd1000; cmd_speed_2 = s2 + 32'd2000;
        cmd_speed_3 = s3 + 32'd3000; cmd_speed_4 = s4 + 32'd4000;
    endtask

    initial begin
        reset_n = 1'b1;
        cmd_valid = 1'b0; motors_on = 1'b0; abort = 1'b0;
        fault_clr = 1'b0; steppers_driving = 1'b0;
        set_cmd(2'd0, 3'b000, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_drive", start_driving, 0);
        chk("rst_enable", stepper_enable, 0);
        chk("rst_fault", fault, 0);
        step(); step();
        reset_n = 1'b1;
        step();
        chk("idle_ready", cmd_ready, 1);

        // MOVE {100,0,0,5}
        set_cmd(2'd0, 3'b111, 100, 0, 0, 5);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("mv_count1", queue_count, 1);
        chk("mv_busy", busy, 1);
        chk("mv_n1_drive", start_driving, 0);
        step();
        chk("mv_load_drive", start_driving, 0);
        step();
        chk("mv_arm_drive", start_driving, 1);
        chk("mv_arm_home", start_homing, 0);
        chk("mv_step1", stepper_step_in_1, 100);
        chk("mv_step4", stepper_step_in_4, 5);
        chk("mv_speed1", stepper_speed_1, 1100);
        chk("mv_homesel", {homez, homey, homex}, 0);
        chk("mv_count0", queue_count, 0);
        step(); step();
        steppers_driving = 1'b1;
        step();
        chk("mv_run_drive", start_driving, 1);
        chk("mv_run_enable", stepper_enable, 1);
        for (int i = 0; i < 19; i++) begin
            step();
            chk("mv_hold_drive", start_driving, 1);
            chk("mv_hold_step1", stepper_step_in_1, 100);
        end
        steppers_driving = 1'b0;
        step();
        chk("mv_done_drive", start_driving, 0);
        chk("mv_done_pulse", cmd_done, 1);
        chk("mv_done_step4", stepper_step_in_4, 5);
        step();
        chk("mv_idle_done", cmd_done, 0);
        chk("mv_idle_busy", busy, 0);
        chk("mv_idle_enable", stepper_enable, 0);
        motors_on = 1'b1;
        step();
        chk("motors_on_en", stepper_enable, 1);
        motors_on = 1'b0;
        step();
        chk("motors_off_en", stepper_enable, 0);

        // HOME axes 101
        set_cmd(2'd1, 3'b101, 0, 0, 0, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("hm_homing", start_homing, 1);
        chk("hm_drive", start_driving, 0);
        chk("hm_x", homex, 1);
        chk("hm_y", homey, 0);
        chk("hm_z", homez, 1);
        steppers_driving = 1'b1;
        step();
        chk("hm_run_homing", start_homing, 1);
        chk("hm_run_drive", start_driving, 0);
        steppers_driving = 1'b0;
        step();
        chk("hm_done", cmd_done, 1);
        chk("hm_done_homing", start_homing, 0);
        step();

        // Fill queue while the FSM sits in RUN, then abort
        set_cmd(2'd0, 3'b000, 1, 0, 0, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        steppers_driving = 1'b1;
        step();
        chk("fq_run", start_driving, 1);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(2'd0, 3'b000, 32'd10 + 32'(i), 1, 0, 0);
            step();
        end
        chk("fq_count4", queue_count, 4);
        chk("fq_ready_full", cmd_ready, 0);
        set_cmd(2'd0, 3'b000, 99, 1, 0, 0);
        step(); step();
        chk("fq_held_count", queue_count, 4);
        steppers_driving = 1'b0;
        step();
        chk("fq_done", cmd_done, 1);
        step(); step();
        chk("fq_load_count", queue_count, 4);
        chk("fq_load_ready", cmd_ready, 0);
        step();
        chk("fq_pop_count", queue_count, 3);
        chk("fq_pop_ready", cmd_ready, 1);
        chk("fq_fifo_order", stepper_step_in_1, 10);
        cmd_valid = 1'b0;
        steppers_driving = 1'b1;
        step();
        chk("ab_run", start_driving, 1);
        chk("ab_count3", queue_count, 3);
        abort = 1'b1;
        step();
        chk("ab_drive_low", start_driving, 0);
        chk("ab_done", cmd_done, 1);
        chk("ab_count0", queue_count, 0);
        chk("ab_ready", cmd_ready, 0);
        abort = 1'b0;
        steppers_driving = 1'b0;
        step();
        chk("ab_idle_done", cmd_done, 0);
        chk("ab_idle_busy", busy, 0);
        step();
        chk("ab_no_second_done", cmd_done, 0);
        chk("ab_stay_idle", busy, 0);

        // Acknowledge timeout
        set_cmd(2'd0, 3'b000, 0, 3, 0, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("to_arm", start_driving, 1);
        for (int i = 0; i < 63; i++) step();
        chk("to_still_arm", start_driving, 1);
        chk("to_no_fault_yet", fault, 0);
        step();
        chk("to_done", cmd_done, 1);
        chk("to_fault", fault, 1);
        chk("to_drive_low", start_driving, 0);
        step(); step(); step();
        chk("to_fault_sticky", fault, 1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("to_fault_clr", fault, 0);

        // Zero-step MOVE completes without a strobe
        set_cmd(2'd0, 3'b000, 0, 0, 0, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("zm_done", cmd_done, 1);
        chk("zm_drive", start_driving, 0);
        chk("zm_fault", fault, 0);
        step();

        // Reserved type: fault set wins over simultaneous clear
        set_cmd(2'd3, 3'b000, 7, 0, 0, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("rs_done", cmd_done, 1);
        chk("rs_fault", fault, 1);
        chk("rs_homing", start_homing, 0);
        chk("rs_drive", start_driving, 0);
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("rs_fault_clr", fault, 0);

        // Reset in the middle of RUN
        set_cmd(2'd0, 3'b000, 77, 0, 0, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        steppers_driving = 1'b1;
        step();
        chk("rr_run_step1", stepper_step_in_1, 77);
        reset_n = 1'b0;
        #1;
        chk("rr_drive", start_driving, 0);
        chk("rr_step1", stepper_step_in_1, 0);
        chk("rr_enable", stepper_enable, 0);
        chk("rr_busy", busy, 0);
        chk("rr_ready", cmd_ready, 0);
        step(); step();
        steppers_driving = 1'b0;
        reset_n = 1'b1;
        step();
        chk("rr_no_done1", cmd_done, 0);
        step();
        chk("rr_no_done2", cmd_done, 0);
        chk("rr_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, command queue entries (power of two, 2..16); ACK_TIMEOUT, default 64, cycles allowed for steppers_driving to rise after a start strobe.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  host command offered.
REQ-005 cmd_ready  output  1  queue can accept the offered command.
REQ-006 cmd_type  input  2  0=MOVE, 1=HOME, 2/3 reserved (accepted, completed as no-op with fault).
REQ-007 cmd_home_axes  input  3  {z,y,x} axes to home (HOME only).
REQ-008 cmd_step_1..cmd_step_4  input  32 each  per-axis step counts (MOVE).
REQ-009 cmd_speed_1..cmd_speed_4  input  32 each  per-axis speed words.
REQ-010 motors_on  input  1  host request to keep drivers enabled while idle.
REQ-011 abort  input  1  level; cancel active command and flush queue.
REQ-012 fault_clr  input  1  single-cycle pulse; clears fault.
REQ-013 steppers_driving  input  1  busy flag from stepper controller.
REQ-014 stepper_step_in_1..4, stepper_speed_1..4  output  32 each  operands driven to stepper controller.
REQ-015 homex, homey, homez  output  1 each  home axis selects.
REQ-016 start_driving, start_homing  output  1 each  mode strobes to stepper controller.
REQ-017 stepper_enable  output  1  driver enable.
REQ-018 cmd_done  output  1  one-cycle pulse per completed, aborted or faulted command.
REQ-019 busy  output  1  queue non-empty or state not IDLE.
REQ-020 fault  output  1  sticky error flag.
REQ-021 queue_count  output  5  entries currently queued.

Function
REQ-022 Queue SHALL be a FIFO of DEPTH entries {type, axes, 4 steps, 4 speeds}; push on cmd_valid & cmd_ready.
REQ-023 cmd_ready SHALL equal (queue_count < DEPTH) & ~abort, from registered count; no push when full even if a pop occurs that cycle.
REQ-024 FSM states: IDLE, LOAD, ARM, RUN, DONE.
REQ-025 IDLE -> LOAD when queue non-empty and abort low; LOAD pops head and registers all operand outputs and home selects in one cycle.
REQ-026 LOAD -> DONE directly (no strobe) for MOVE with all four step counts zero, for HOME with axes 3'b000, and for reserved types (reserved also sets fault); otherwise LOAD -> ARM.
REQ-027 ARM SHALL assert start_driving (MOVE) or start_homing (HOME); -> RUN when steppers_driving=1; -> DONE with fault set if steppers_driving stays 0 for ACK_TIMEOUT cycles in ARM.
REQ-028 RUN SHALL hold the same strobe; -> DONE on first cycle steppers_driving=0.
REQ-029 DONE SHALL deassert both strobes, pulse cmd_done for exactly one cycle, -> IDLE; hence at least one strobe-low cycle separates consecutive commands.
REQ-030 start_driving and start_homing SHALL never be high in the same cycle; both SHALL be low in IDLE, LOAD, DONE.
REQ-031 Operand outputs and home selects SHALL remain stable from LOAD until the next LOAD.
REQ-032 abort in ARM or RUN SHALL force DONE next cycle (strobes low next cycle, cmd_done pulses) and empty the queue; abort in IDLE/LOAD/DONE SHALL empty the queue without a cmd_done pulse beyond one already due.
REQ-033 stepper_enable SHALL equal motors_on | (state != IDLE), registered.
REQ-034 Latency: command pushed at cycle N into empty queue with FSM in IDLE -> LOAD at N+1, strobe high at N+2.
REQ-035 fault SHALL stay set until fault_clr; fault_clr coincident with a new fault event leaves fault set.

Reset
REQ-036 reset_n low SHALL asynchronously force state IDLE, queue empty, all outputs 0 (operands, strobes, home selects, stepper_enable, cmd_done, busy, fault, queue_count), cmd_ready 0 while reset_n is low; reset mid-command drops the command without cmd_done.

Verification
REQ-037 MOVE steps {100,0,0,5}: strobe start_driving at N+2, model raises steppers_driving 3 cycles later for 20 cycles -> start_driving low and cmd_done pulse one cycle after steppers_driving falls, operands stable throughout.
REQ-038 Push 5 commands back-to-back with DEPTH=4 and FSM held in RUN -> cmd_ready low after 4th, queue_count=4, 5th held until a pop.
REQ-039 HOME axes 3'b101 -> homex=1, homey=0, homez=1, start_homing only; start_driving never high.
REQ-040 MOVE with steppers_driving tied 0 -> cmd_done and fault after 64 ARM cycles; fault stays until fault_clr.
REQ-041 abort during RUN with 3 queued -> strobe low next cycle, one cmd_done, queue_count=0, busy falls once in IDLE.
REQ-042 reset_n low during RUN -> all outputs 0 immediately, no cmd_done after release.
